// File: rtl/btn_pkg.sv
// Shared definitions for the push-button gesture path.
// The state encoding is also decoded by the CSR block for debug readback,
// so the numeric values below must stay stable.
package btn_pkg;

    // Gesture FSM state, 3-bit encoding visible to software
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PRESS1 = 3'd1,
        ST_WAIT2  = 3'd2,
        ST_PRESS2 = 3'd3,
        ST_LONG   = 3'd4
    } btn_state_t;

    // Defaults for a 1 ms tick: 1 s long press, 250 ms double-click window
    localparam int BTN_CNT_W      = 16;
    localparam int BTN_LONG_TICKS = 1000;
    localparam int BTN_DBL_TICKS  = 250;

    // True while the FSM believes the button is held down
    function automatic logic state_is_held(input btn_state_t s);
        return (s == ST_PRESS1) || (s == ST_PRESS2) || (s == ST_LONG);
    endfunction

endpackage

// File: rtl/button_event_edge_det.sv
// Edge detector for the debounced button level.
// Registers btn and produces combinational rise/fall strobes. Both strobes are
// masked on the first clock after reset so a button already held at reset
// release is not reported as a press.
module edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic rise,
    output logic fall
);

    logic btn_q;
    logic armed;

    // Previous-level register plus a one-shot arm flag set after the first clock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_q <= 1'b0;
            armed <= 1'b0;
        end else begin
            btn_q <= btn;
            armed <= 1'b1;
        end
    end

    assign rise = armed &  btn & ~btn_q;
    assign fall = armed & ~btn &  btn_q;

endmodule

// File: rtl/button_event.sv
// Push-button gesture classifier.
// Turns the debounced level into one-cycle pulses for press, release, single
// click, double click and long press. Time is counted in ticks of an external
// enable. "release" is a reserved word, so the falling-edge pulse is named
// released.
module button_event
    import btn_pkg::*;
#(
    parameter int CNT_W      = BTN_CNT_W,
    parameter int LONG_TICKS = BTN_LONG_TICKS,
    parameter int DBL_TICKS  = BTN_DBL_TICKS
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic btn,
    output logic press,
    output logic released,
    output logic single_click,
    output logic double_click,
    output logic long_press,
    output logic busy
);

    // Counter values at which the respective timeout fires on the next tick
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 1);
    localparam logic [CNT_W-1:0] DBL_LAST  = CNT_W'(DBL_TICKS - 1);

    logic             rise;
    logic             fall;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             long_hit;
    logic             dbl_hit;
    btn_state_t       state;

    edge_det u_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn),
        .rise  (rise),
        .fall  (fall)
    );

    // Saturating increment so a very long hold cannot wrap into a false timeout
    assign cnt_inc  = (cnt == '1) ? cnt : cnt + CNT_W'(1);
    assign long_hit = tick && (cnt == LONG_LAST);
    assign dbl_hit  = tick && (cnt == DBL_LAST);

    // Gesture FSM with tick counter and registered one-cycle output pulses.
    // Edges are tested before timeouts so an edge always wins a tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            press        <= 1'b0;
            released     <= 1'b0;
            single_click <= 1'b0;
            double_click <= 1'b0;
            long_press   <= 1'b0;
        end else begin
            press        <= rise;
            released     <= fall;
            single_click <= 1'b0;
            double_click <= 1'b0;
            long_press   <= 1'b0;
            if (tick) begin
                cnt <= cnt_inc;
            end
            case (state)
                ST_IDLE: begin
                    if (rise) begin
                        state <= ST_PRESS1;
                        cnt   <= '0;
                    end
                end
                ST_PRESS1: begin
                    if (fall) begin
                        state <= ST_WAIT2;
                        cnt   <= '0;
                    end else if (long_hit) begin
                        long_press <= 1'b1;
                        state      <= ST_LONG;
                        cnt        <= '0;
                    end
                end
                ST_WAIT2: begin
                    if (rise) begin
                        state <= ST_PRESS2;
                        cnt   <= '0;
                    end else if (dbl_hit) begin
                        single_click <= 1'b1;
                        state        <= ST_IDLE;
                        cnt          <= '0;
                    end
                end
                ST_PRESS2: begin
                    if (fall) begin
                        double_click <= 1'b1;
                        state        <= ST_IDLE;
                        cnt          <= '0;
                    end else if (long_hit) begin
                        // Holding the second press turns it into a long press;
                        // the pending double click is dropped.
                        long_press <= 1'b1;
                        state      <= ST_LONG;
                        cnt        <= '0;
                    end
                end
                ST_LONG: begin
                    if (fall) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_button_event.sv
// Scoreboard bench for button_event with LONG_TICKS=4, DBL_TICKS=3.
// Stimulus pushes hand-computed {cycle, pulse vector} events; a monitor pops
// one entry each time the DUT raises any pulse output and compares both.
module tb_button_event;

    localparam logic [4:0] EP = 5'b00001;  // press
    localparam logic [4:0] ER = 5'b00010;  // release
    localparam logic [4:0] ES = 5'b00100;  // single_click
    localparam logic [4:0] ED = 5'b01000;  // double_click
    localparam logic [4:0] EL = 5'b10000;  // long_press

    typedef struct {
        int         cyc;
        logic [4:0] v;
    } exp_t;

    logic clk;
    logic rst_n;
    logic tick;
    logic btn;
    logic press;
    logic released;
    logic single_click;
    logic double_click;
    logic long_press;
    logic busy;

    int   cyc;
    int   n_cmp;
    int   n_bad;
    int   t0;
    int   t1;
    int   t2;
    exp_t q[$];

    logic [4:0] outs;
    assign outs = {long_press, double_click, single_click, released, press};

    button_event #(
        .CNT_W      (16),
        .LONG_TICKS (4),
        .DBL_TICKS  (3)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tick         (tick),
        .btn          (btn),
        .press        (press),
        .released     (released),
        .single_click (single_click),
        .double_click (double_click),
        .long_press   (long_press),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Queue an expected pulse vector; entries for the same cycle are merged
    task automatic push(input int c, input logic [4:0] v);
        exp_t e;
        if (q.size() > 0 && q[q.size()-1].cyc == c) begin
            q[q.size()-1].v = q[q.size()-1].v | v;
        end else begin
            e.cyc = c;
            e.v   = v;
            q.push_back(e);
        end
    endtask

    // Monitor: every visible pulse must match the next scoreboard entry
    always @(negedge clk) begin
        exp_t e;
        if (outs !== 5'b0) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_pulse: got %b want none (cyc %0d)", outs, cyc);
            end else begin
                e = q.pop_front();
                check("pulse_cycle", cyc, e.cyc);
                check("pulse_vector", {27'd0, outs}, {27'd0, e.v});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc   = 0;
        n_cmp = 0;
        n_bad = 0;
        btn   = 1'b0;
        tick  = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_outs", {27'd0, outs}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // 1: short press then silence -> single click 3 ticks after the fall
        t0 = cyc; btn = 1'b1; push(t0 + 1, EP);
        repeat (2) @(negedge clk);
        btn = 1'b0; push(t0 + 3, ER); push(t0 + 6, ES);
        repeat (10) @(negedge clk);
        check("t1_busy_end", {31'd0, busy}, 32'd0);

        // 2: two short presses -> double click together with the 2nd release
        t0 = cyc; btn = 1'b1; push(t0 + 1, EP);
        repeat (2) @(negedge clk);
        btn = 1'b0; push(t0 + 3, ER);
        @(negedge clk);
        btn = 1'b1; push(t0 + 4, EP);
        repeat (2) @(negedge clk);
        btn = 1'b0; push(t0 + 6, ER | ED);
        repeat (10) @(negedge clk);
        check("t2_busy_end", {31'd0, busy}, 32'd0);

        // 3: 10-cycle hold -> long press once, 4 ticks after entering PRESS1
        t0 = cyc; btn = 1'b1; push(t0 + 1, EP); push(t0 + 5, EL);
        repeat (10) @(negedge clk);
        check("t3_busy_held", {31'd0, busy}, 32'd1);
        btn = 1'b0; push(t0 + 11, ER);
        @(negedge clk);
        check("t3_busy_after_fall", {31'd0, busy}, 32'd0);
        repeat (6) @(negedge clk);

        // 4: fall on the same clock as the long timeout -> edge wins, then single
        t0 = cyc; btn = 1'b1; push(t0 + 1, EP);
        repeat (4) @(negedge clk);
        btn = 1'b0; push(t0 + 5, ER); push(t0 + 8, ES);
        @(negedge clk);
        check("t4_busy_wait2", {31'd0, busy}, 32'd1);
        repeat (8) @(negedge clk);
        check("t4_busy_end", {31'd0, busy}, 32'd0);

        // 5: no ticks -> no timeouts, edges still pulse, FSM parks in WAIT2
        tick = 1'b0;
        t0 = cyc; btn = 1'b1; push(t0 + 1, EP);
        repeat (10) @(negedge clk);
        btn = 1'b0; push(t0 + 11, ER);
        repeat (10) @(negedge clk);
        check("t5_busy_stalled", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick  = 1'b1;
        repeat (3) @(negedge clk);
        check("t5_busy_after_rst", {31'd0, busy}, 32'd0);

        // 6: reset during PRESS2 with btn held -> no pulses, IDLE until fall+rise
        t0 = cyc; btn = 1'b1; push(t0 + 1, EP);
        repeat (2) @(negedge clk);
        btn = 1'b0; push(t0 + 3, ER);
        @(negedge clk);
        btn = 1'b1; push(t0 + 4, EP);
        repeat (2) @(negedge clk);
        check("t6_busy_press2", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_outs", {27'd0, outs}, 32'd0);
        check("t6_rst_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("t6_idle_held", {31'd0, busy}, 32'd0);
        t1 = cyc; btn = 1'b0; push(t1 + 1, ER);
        repeat (3) @(negedge clk);
        check("t6_idle_after_fall", {31'd0, busy}, 32'd0);
        t2 = cyc; btn = 1'b1; push(t2 + 1, EP);
        repeat (2) @(negedge clk);
        btn = 1'b0; push(t2 + 3, ER); push(t2 + 6, ES);
        @(negedge clk);
        check("t6_busy_regesture", {31'd0, busy}, 32'd1);
        repeat (8) @(negedge clk);

        // Anything left in the scoreboard is a pulse the DUT never produced
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL missing_pulse: got none want %b at cyc %0d", e.v, e.cyc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
